// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined imem requests and buffers
// returned words in an in-order queue feeding IF/ID. Define PREFETCH_BYPASS_EN for the empty-queue bypass.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          run_q;
  logic [OW-1:0] out_q, out_d, disc_q, disc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q [DEPTH];

  logic [31:0] redir_pc_s;
  logic        rv_s, keep_s, issue_s, byp_s, pop_s, pop_q_s, push_s;

  assign redir_pc_s = redirect_pc_i & 32'hFFFF_FFFC;
  // A response with nothing outstanding is a leftover from before reset and is ignored.
  assign rv_s    = imem_rvalid_i && (out_q != {OW{1'b0}});
  assign keep_s  = rv_s && !redirect_i && (disc_q == {OW{1'b0}});
  assign imem_req_o = run_q && !redirect_i && (32'(out_q) < 32'(MAX_OUT)) &&
                      ((32'(count_q) + 32'(out_q)) < 32'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign issue_s     = imem_req_o && imem_gnt_i;

`ifdef PREFETCH_BYPASS_EN
  assign byp_s = keep_s && (count_q == {CW{1'b0}});
`else
  assign byp_s = 1'b0;
`endif

  // Head presentation: queue head, bypassed response, or a bubble holding the last PC.
  always_comb begin
    if (count_q != {CW{1'b0}}) begin
      instr_valid_o = 1'b1;
      instr_o       = instr_mem_q[rd_q];
      pc_o          = pc_mem_q[rd_q];
    end else if (byp_s) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rdata_i;
      pc_o          = resp_pc_q;
    end else begin
      instr_valid_o = 1'b0;
      instr_o       = NOP;
      pc_o          = last_pc_q;
    end
  end
  assign pc_plus4_o = pc_o + 32'd4;

  assign pop_s   = instr_valid_o && !stall_i && !redirect_i;
  assign pop_q_s = pop_s && (count_q != {CW{1'b0}});
  assign push_s  = keep_s && !(byp_s && pop_s);

  // Next-state: redirect flushes everything; responses still in flight become discards.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    last_pc_d  = last_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect_i) begin
      fetch_pc_d = redir_pc_s;
      resp_pc_d  = redir_pc_s;
      out_d      = out_q - OW'(rv_s);
      disc_d     = out_q - OW'(rv_s);
      count_d    = {CW{1'b0}};
      rd_d       = {AW{1'b0}};
      wr_d       = {AW{1'b0}};
    end else begin
      if (issue_s) fetch_pc_d = fetch_pc_q + 32'd4;
      else         fetch_pc_d = fetch_pc_q;
      out_d = out_q + OW'(issue_s) - OW'(rv_s);
      if (rv_s && !keep_s) disc_d = disc_q - OW'(1'b1);
      else                 disc_d = disc_q;
      // Kept responses are sequential between redirects, so the tag is a running PC.
      if (keep_s) resp_pc_d = resp_pc_q + 32'd4;
      else        resp_pc_d = resp_pc_q;
      if (push_s) wr_d = wr_q + AW'(1'b1);
      else        wr_d = wr_q;
      if (pop_q_s) rd_d = rd_q + AW'(1'b1);
      else         rd_d = rd_q;
      count_d = count_q + CW'(push_s) - CW'(pop_q_s);
      if (pop_s) last_pc_d = pc_o;
      else       last_pc_d = last_pc_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      run_q      <= 1'b0;
      out_q      <= {OW{1'b0}};
      disc_q     <= {OW{1'b0}};
      count_q    <= {CW{1'b0}};
      rd_q       <= {AW{1'b0}};
      wr_q       <= {AW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      run_q      <= 1'b1;
      out_q      <= out_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Queue storage; contents are only observed when count_q covers them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_q[wr_q] <= imem_rdata_i;
      pc_mem_q[wr_q]    <= resp_pc_q;
    end
  end

  if_prefetch_queue_chk #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .CW(CW), .OW(OW)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_q_s),
    .count_i (count_q),
    .out_i   (out_q)
  );
endmodule

// Simulation checks on queue occupancy and outstanding-request credits.
module if_prefetch_queue_chk #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int CW      = 3,
  parameter int OW      = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push_i,
  input logic          pop_i,
  input logic [CW-1:0] count_i,
  input logic [OW-1:0] out_i
);
  // Overflow and credit violations are design errors.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_i && !pop_i && (32'(count_i) == 32'(DEPTH))))
        else $error("prefetch queue overflow");
      assert (32'(out_i) <= 32'(MAX_OUT))
        else $error("outstanding requests exceed credit");
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed + randomised bench for if_prefetch_queue with an in-order imem model and a PC scoreboard.
module tb_if_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = 32'd0;
  logic        instr_valid_o;
  logic [31:0] instr_o, pc_o, pc_plus4_o;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  int checks = 0, errors = 0, cyc = 0, last_due = 0;
  int lat_lo = 1, lat_hi = 1;
  bit gnt_rand = 1'b0, spur = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = RESET_PC;
  bit          consumed, last_valid, last_req;
  logic [31:0] consumed_pc, last_addr, last_pc;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive imem model at negedge, sample and score at negedge+1, advance model after posedge.
  task automatic step();
    logic        rv;
    logic [31:0] e;
    int          due;
    @(negedge clk);
    rv = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    imem_gnt_i    = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rvalid_i = rv || spur;
    imem_rdata_i  = rv ? word_at(pend_addr[0]) : 32'hDEAD_BEEF;
    #1;
    consumed = 1'b0;
    chk("inflight_le_max", 32'(pend_addr.size() <= MAX_OUT), 32'd1);
    if (redirect_i) begin
      chk("req_during_redirect", {31'd0, imem_req_o}, 32'd0);
      exp_q.delete();
      exp_fetch = redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      if (imem_req_o && imem_gnt_i) begin
        chk("fetch_addr", imem_addr_o, exp_fetch);
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        chk("queue_plus_inflight_le_depth", 32'(exp_q.size() <= DEPTH), 32'd1);
      end
      if (instr_valid_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_pc", pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pc_o", pc_o, e);
          chk("instr_o", instr_o, word_at(e));
          chk("pc_plus4_o", pc_plus4_o, e + 32'd4);
          consumed = 1'b1;
          consumed_pc = pc_o;
        end
      end
    end
    last_valid = instr_valid_o;
    last_req   = imem_req_o;
    last_addr  = imem_addr_o;
    last_pc    = pc_o;
    @(posedge clk);
    if (rv) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (last_req && imem_gnt_i) begin
      due = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (due <= last_due) due = last_due + 1;
      pend_addr.push_back(last_addr);
      pend_due.push_back(due);
      last_due = due;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_pc4", pc_plus4_o, RESET_PC + 32'd4);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    stall_i = 1'b0; redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    pend_addr.delete(); pend_due.delete(); exp_q.delete();
    exp_fetch = RESET_PC;
    last_due = cyc;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int          first_v, n, expected_first;
    bit          found;
    logic [31:0] held_pc;
    #3;
    do_reset();

    // 1: streaming with gnt=1 and 1-cycle latency
    first_v = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (last_valid && first_v == 0) first_v = k;
    end
`ifdef PREFETCH_BYPASS_EN
    expected_first = 3;
`else
    expected_first = 4;
`endif
    chk("first_valid_step", 32'(first_v), 32'(expected_first));
    repeat (8) step();

    // 2: stall fills the queue, head holds, then drains in order
    stall_i = 1'b1;
    step();
    held_pc = last_pc;
    repeat (9) step();
    chk("stall_req_dropped", {31'd0, last_req}, 32'd0);
    chk("stall_valid", {31'd0, last_valid}, 32'd1);
    chk("stall_head_stable", last_pc, held_pc);
    stall_i = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (consumed) n++;
    end
    chk("drain_four", 32'(n), 32'd4);

    // 3: redirect with two outstanding
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pend_addr.size() == 2) found = 1'b1;
      else step();
    end
    chk("wait_two_outstanding", {31'd0, found}, 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    step();
    redirect_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (consumed) found = 1'b1;
    end
    chk("redirect_first_pc", consumed_pc, 32'h0000_0100);

    // 4: redirect coinciding with rvalid and stall, misaligned target
    lat_lo = 1; lat_hi = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) found = 1'b1;
      else step();
    end
    chk("wait_rvalid_cycle", {31'd0, found}, 32'd1);
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
    step();
    redirect_i = 1'b0;
    step();
    chk("redir_rv_queue_empty", {31'd0, last_valid}, 32'd0);
    chk("redir_rv_addr", last_addr, 32'h0000_0200);
    stall_i = 1'b0;
    repeat (6) step();

    // 5: random grant, latency 1..5, random stalls and redirects
    gnt_rand = 1'b1; lat_lo = 1; lat_hi = 5;
    for (int k = 0; k < 400; k++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 31) == 0);
      redirect_pc_i = $urandom & 32'h0000_FFFF;
      step();
    end
    stall_i = 1'b0; redirect_i = 1'b0; gnt_rand = 1'b0;
    repeat (10) step();

    // 6: reset mid-stream with two outstanding, stray responses afterwards
    lat_lo = 4; lat_hi = 4;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pend_addr.size() == 2) found = 1'b1;
      else step();
    end
    chk("wait_two_outstanding_rst", {31'd0, found}, 32'd1);
    do_reset();
    lat_lo = 1; lat_hi = 1;
    spur = 1'b1;
    step();
    step();
    spur = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (consumed) found = 1'b1;
    end
    chk("restart_pc", consumed_pc, RESET_PC);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
